multicycle_control: RTL
=======================

# multicycle_control

Moore-style control state machine for the multicycle RV64I core. It sequences the shared datapath: PC, instruction register, register file, single ALU, immediate generator and data memory. It decodes the opcode held in the instruction register and steps each instruction through fetch, decode, execute, memory and write-back cycles. Data-memory accesses wait on a ready/done handshake.

## Interface
- No parameters; opcode and state encodings are fixed below.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `INSTR` in 32: instruction register contents; opcode is `INSTR[6:0]`, funct3 is `INSTR[14:12]`.
- `ZERO` in 1: ALU zero flag.
- `MEM_DONE` in 1: data memory completed the current access.
- `IR_WRITE` out 1: load IR and OLD_PC.
- `PC_WRITE` out 1: load PC from the PC_SRC mux.
- `PC_SRC` out 2: 00 ALU result, 01 ALUOUT, 10 ALU result masked with bit 0 cleared (JALR).
- `ALU_SRC_A` out 2: 00 PC, 01 rs1, 10 OLD_PC, 11 zero.
- `ALU_SRC_B` out 2: 00 rs2, 01 constant 4, 10 sign-extended immediate.
- `ALU_OP` out 2: 00 ADD, 01 SUB, 10 R-type funct decode, 11 I-type funct decode.
- `ALUOUT_WRITE` out 1: latch ALU result into ALUOUT.
- `MEM_READ` out 1: data memory read request.
- `MEM_WRITE` out 1: data memory write request.
- `MDR_WRITE` out 1: latch read data.
- `REG_WRITE` out 1: register file write.
- `MEM_TO_REG` out 2: write-back source; 00 ALUOUT, 01 MDR, 10 PC.
- `STATE` out 4: current state, for debug.
- `ILLEGAL` out 1: sticky unknown-opcode flag.

## Operation
- States and encodings:
  - 0 RST, 1 FETCH, 2 DECODE, 3 EXEC_R, 4 EXEC_I, 5 ADDR, 6 MEM_RD, 7 WB_LOAD, 8 MEM_WR.
  - 9 BRANCH, 10 JAL, 11 JALR, 12 LUI, 13 WB_ALU, 14 HALT, 15 TRAP.
- All outputs are decoded from the registered state only. Any output not listed for a state is 0.
- RST: all outputs 0. Goes to FETCH.
- FETCH: IR_WRITE, PC_WRITE, PC_SRC=00, A=00, B=01, ADD. Goes to DECODE.
- DECODE: A=10, B=10, ADD, ALUOUT_WRITE (branch/jump target). Dispatches on opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 and 0100011 → ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 1110011 → see Configuration
  - anything else → TRAP
- EXEC_R: A=01, B=00, ALU_OP=10, ALUOUT_WRITE. Goes to WB_ALU.
- EXEC_I: A=01, B=10, ALU_OP=11, ALUOUT_WRITE. Goes to WB_ALU.
- LUI: A=11, B=10, ADD, ALUOUT_WRITE. Goes to WB_ALU.
- WB_ALU: REG_WRITE, MEM_TO_REG=00. Goes to FETCH.
- ADDR: A=01, B=10, ADD, ALUOUT_WRITE. Goes to MEM_RD if the opcode is 0000011, else to MEM_WR.
- MEM_RD: MEM_READ held, MDR_WRITE. Stays until MEM_DONE=1, then goes to WB_LOAD.
- WB_LOAD: REG_WRITE, MEM_TO_REG=01. Goes to FETCH.
- MEM_WR: MEM_WRITE held. Stays until MEM_DONE=1, then goes to FETCH.
- BRANCH: A=01, B=00, SUB, PC_SRC=01. PC_WRITE is combinational on state and inputs:
  - funct3 000 (BEQ): PC_WRITE = ZERO.
  - funct3 001 (BNE): PC_WRITE = !ZERO.
  - other funct3: PC_WRITE = 0.
  - Goes to FETCH.
- JAL: REG_WRITE, MEM_TO_REG=10, PC_WRITE, PC_SRC=01. Goes to FETCH.
- JALR: A=01, B=10, ADD, PC_SRC=10, PC_WRITE, REG_WRITE, MEM_TO_REG=10. Goes to FETCH.
- TRAP: sets ILLEGAL. Stays in TRAP until reset.

## Timing
- Cycles per instruction:
  - R-type, I-type, LUI: 4.
  - Branch, JAL, JALR: 3.
  - Store: 4 + wait cycles.
  - Load: 5 + wait cycles.
- MEM_DONE is sampled only in MEM_RD and MEM_WR; it is ignored in every other state.
- MEM_DONE already high on the first MEM_RD/MEM_WR cycle means a single-cycle access: exit on the next edge.
- Reset in any state, including mid-wait:
  - Next edge: STATE=RST, ILLEGAL=0, all outputs 0.
  - Any pending memory request is dropped.
- After reset deassertion: RST for 1 cycle, then FETCH.
- Reset has priority over every transition.

## Configuration
- `EBREAK_HALT_EN` defined:
  - Opcode 1110011 with `INSTR[20]=1` (EBREAK) goes to HALT. HALT drives all outputs 0 and stays until reset.
  - ECALL (`INSTR[20]=0`) returns to FETCH as a no-op.
- `EBREAK_HALT_EN` undefined:
  - Opcode 1110011 always returns to FETCH as a no-op.
  - HALT is unreachable.

## Test plan
- ADD x3,x1,x2 (0x002081B3) after reset:
  - STATE sequence 0,1,2,3,13,1.
  - REG_WRITE=1 only in state 13.
- LW with MEM_DONE held low 3 cycles:
  - MEM_READ high for exactly 4 cycles.
  - Then WB_LOAD with MEM_TO_REG=01.
  - 8 cycles from FETCH to next FETCH.
- BEQ:
  - ZERO=1: PC_WRITE=1, PC_SRC=01 in BRANCH.
  - ZERO=0: PC_WRITE=0.
  - BNE inverts both cases.
- Opcode 0x7F: TRAP, ILLEGAL=1 persists 10 cycles; reset clears it to RST then FETCH.
- Reset asserted during MEM_WR wait: MEM_WRITE=0 and STATE=0 on the next edge.
- EBREAK (0x00100073):
  - With `EBREAK_HALT_EN`: STATE=14 held.
  - Without: returns to FETCH after DECODE.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore control FSM for the multicycle RV64I core. It steps every
//   instruction through fetch / decode / execute / memory / write-back
//   and drives the select and enable lines of the shared datapath.
//   Optional feature macro: EBREAK_HALT_EN. When defined, EBREAK parks
//   the FSM in HALT. When undefined, the whole SYSTEM opcode is a no-op.
// Ports
//   clk, reset         clock, synchronous active-high reset
//   INSTR              IR contents (opcode [6:0], funct3 [14:12])
//   ZERO               ALU zero flag (branch resolution)
//   MEM_DONE           data memory handshake completion
//   IR_WRITE .. MEM_TO_REG  datapath controls
//   STATE              current state (debug)
//   ILLEGAL            sticky unknown-opcode flag
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] INSTR,
    input  logic        ZERO,
    input  logic        MEM_DONE,
    output logic        IR_WRITE,
    output logic        PC_WRITE,
    output logic [1:0]  PC_SRC,
    output logic [1:0]  ALU_SRC_A,
    output logic [1:0]  ALU_SRC_B,
    output logic [1:0]  ALU_OP,
    output logic        ALUOUT_WRITE,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        MDR_WRITE,
    output logic        REG_WRITE,
    output logic [1:0]  MEM_TO_REG,
    output logic [3:0]  STATE,
    output logic        ILLEGAL
);
    typedef enum logic [3:0] {
        S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4, S_ADDR = 4'd5, S_MEM_RD = 4'd6, S_WB_LOAD = 4'd7,
        S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
        S_LUI = 4'd12, S_WB_ALU = 4'd13, S_HALT = 4'd14, S_TRAP = 4'd15
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       aluout_write;
        logic       mem_read;
        logic       mem_write;
        logic       mdr_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_SYS = 7'b1110011;

    state_t state, nxt;
    ctrl_t  ctrl;
    logic   br_take;

    function automatic state_t next_state(state_t s, logic [31:0] ir, logic done);
        state_t n;
        n = s;
        case (s)
            S_RST:    n = S_FETCH;
            S_FETCH:  n = S_DECODE;
            S_DECODE: begin
                case (ir[6:0])
                    OP_R:            n = S_EXEC_R;
                    OP_I:            n = S_EXEC_I;
                    OP_LD, OP_ST:    n = S_ADDR;
                    OP_BR:           n = S_BRANCH;
                    OP_JAL:          n = S_JAL;
                    OP_JALR:         n = S_JALR;
                    OP_LUI:          n = S_LUI;
`ifdef EBREAK_HALT_EN
                    OP_SYS:          n = ir[20] ? S_HALT : S_FETCH;
`else
                    OP_SYS:          n = S_FETCH;
`endif
                    default:         n = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_LUI: n = S_WB_ALU;
            S_ADDR:   n = (ir[6:0] == OP_LD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: n = done ? S_WB_LOAD : S_MEM_RD;
            S_MEM_WR: n = done ? S_FETCH : S_MEM_WR;
            S_WB_LOAD, S_WB_ALU, S_BRANCH, S_JAL, S_JALR: n = S_FETCH;
            default:  n = s;  // HALT and TRAP hold until reset
        endcase
        return n;
    endfunction

    function automatic ctrl_t decode_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
            S_DECODE:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; c.aluout_write = 1'b1; end
            S_EXEC_R:  begin c.alu_src_a = 2'b01; c.alu_op = 2'b10; c.aluout_write = 1'b1; end
            S_EXEC_I:  begin
                c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = 2'b11; c.aluout_write = 1'b1;
            end
            S_LUI:     begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b10; c.aluout_write = 1'b1; end
            S_ADDR:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.aluout_write = 1'b1; end
            S_WB_ALU:  c.reg_write = 1'b1;
            S_MEM_RD:  begin c.mem_read = 1'b1; c.mdr_write = 1'b1; end
            S_WB_LOAD: begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
            S_MEM_WR:  c.mem_write = 1'b1;
            // Branch PC_WRITE depends on ZERO in the same cycle, so it is
            // added combinationally below rather than registered here.
            S_BRANCH:  begin c.alu_src_a = 2'b01; c.alu_op = 2'b01; c.pc_src = 2'b01; end
            S_JAL:     begin
                c.reg_write = 1'b1; c.mem_to_reg = 2'b10; c.pc_write = 1'b1; c.pc_src = 2'b01;
            end
            S_JALR:    begin
                c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_src = 2'b10; c.pc_write = 1'b1;
                c.reg_write = 1'b1; c.mem_to_reg = 2'b10;
            end
            default:   c = '0;
        endcase
        return c;
    endfunction

    assign nxt = next_state(state, INSTR, MEM_DONE);

    // Outputs are registered from the next state so they line up with the
    // state they belong to without a decode stage after the state flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_RST;
            ctrl    <= '0;
            ILLEGAL <= 1'b0;
        end else begin
            state <= nxt;
            ctrl  <= decode_ctrl(nxt);
            if (nxt == S_TRAP) ILLEGAL <= 1'b1;
        end
    end

    always_comb begin
        br_take = 1'b0;
        case (INSTR[14:12])
            3'b000:  br_take = ZERO;
            3'b001:  br_take = !ZERO;
            default: br_take = 1'b0;
        endcase
    end

    assign IR_WRITE     = ctrl.ir_write;
    assign PC_WRITE     = ctrl.pc_write | ((state == S_BRANCH) & br_take);
    assign PC_SRC       = ctrl.pc_src;
    assign ALU_SRC_A    = ctrl.alu_src_a;
    assign ALU_SRC_B    = ctrl.alu_src_b;
    assign ALU_OP       = ctrl.alu_op;
    assign ALUOUT_WRITE = ctrl.aluout_write;
    assign MEM_READ     = ctrl.mem_read;
    assign MEM_WRITE    = ctrl.mem_write;
    assign MDR_WRITE    = ctrl.mdr_write;
    assign REG_WRITE    = ctrl.reg_write;
    assign MEM_TO_REG   = ctrl.mem_to_reg;
    assign STATE        = state;

    // Operand fields are consumed by the datapath, not by the control.
    logic unused_instr;
    assign unused_instr = &{1'b0, INSTR[31:15], INSTR[11:7]};
endmodule
